// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment glyph table and scan-decoder state type
package seg7_pkg;

    // Active-low glyphs, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h18;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    localparam logic [6:0] GLYPH_BARS  = 7'h36;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - combinational active-low glyph to nibble decoder
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_err
);

    always_comb begin
        o_nibble = 4'h0;
        o_err    = 1'b0;
        case (i_seg)
            GLYPH_0: o_nibble = 4'h0;
            GLYPH_1: o_nibble = 4'h1;
            GLYPH_2: o_nibble = 4'h2;
            GLYPH_3: o_nibble = 4'h3;
            GLYPH_4: o_nibble = 4'h4;
            GLYPH_5: o_nibble = 4'h5;
            GLYPH_6: o_nibble = 4'h6;
            GLYPH_7: o_nibble = 4'h7;
            GLYPH_8: o_nibble = 4'h8;
            GLYPH_9: o_nibble = 4'h9;
            GLYPH_A: o_nibble = 4'hA;
            GLYPH_B: o_nibble = 4'hB;
            GLYPH_C: o_nibble = 4'hC;
            GLYPH_D: o_nibble = 4'hD;
            GLYPH_E: o_nibble = 4'hE;
            GLYPH_F: o_nibble = 4'hF;
            default: o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - snoops a multiplexed seven-segment bus and rebuilds the displayed frame
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n_i,
    input  logic [DIGITS-1:0]     dig_en_n_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     err_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int BW = DIGITS + 7;

    logic [6:0]          r_seg_meta, r_seg_sync;
    logic [DIGITS-1:0]   r_en_meta, r_en_sync;
    logic [BW-1:0]       r_bus_prev;
    logic [CW-1:0]       r_cnt;
    logic                r_captured;
    logic [DIGITS-1:0]   r_mask;
    logic [4*DIGITS-1:0] r_stage_val;
    logic [DIGITS-1:0]   r_stage_err;
    state_t              r_state;

    logic [BW-1:0]       w_bus;
    logic [DIGITS-1:0]   w_en;
    logic                w_onehot, w_same, w_fire;
    logic [3:0]          w_nibble;
    logic                w_err;
    logic [4*DIGITS-1:0] w_stage_val_nxt;
    logic [DIGITS-1:0]   w_stage_err_nxt;
    logic [DIGITS-1:0]   w_mask_nxt;
    logic                w_stage_we, w_load, w_valid_nxt, w_ovr_nxt;
    state_t              w_state_nxt;

    assign w_bus    = {r_en_sync, r_seg_sync};
    assign w_en     = ~r_en_sync;
    assign w_onehot = (w_en != '0) && ((w_en & (w_en - DIGITS'(1))) == '0);
    assign w_same   = (w_bus == r_bus_prev);
    // Fires on the step into the saturated count, so one dwell yields one capture
    assign w_fire   = w_same && (r_cnt == CW'(STABLE_CYCLES - 2)) && !r_captured && w_onehot;

    seg7_glyph_decode u_decode (
        .i_seg    (r_seg_sync),
        .o_nibble (w_nibble),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_meta <= '0;
            r_seg_sync <= '0;
            r_en_meta  <= '0;
            r_en_sync  <= '0;
            r_bus_prev <= '0;
            r_cnt      <= '0;
            r_captured <= 1'b0;
        end else begin
            r_seg_meta <= seg_n_i;
            r_seg_sync <= r_seg_meta;
            r_en_meta  <= dig_en_n_i;
            r_en_sync  <= r_en_meta;
            r_bus_prev <= w_bus;
            if (!w_same) begin
                r_cnt      <= '0;
                r_captured <= 1'b0;
            end else begin
                if (r_cnt != CW'(STABLE_CYCLES - 1)) r_cnt <= r_cnt + CW'(1);
                if (w_fire) r_captured <= 1'b1;
            end
        end
    end

    // Staging with the current capture merged in, so a completing capture lands in the frame
    always_comb begin
        w_stage_val_nxt = r_stage_val;
        w_stage_err_nxt = r_stage_err;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_en[i]) begin
                w_stage_val_nxt[4*i +: 4] = w_nibble;
                w_stage_err_nxt[i]        = w_err;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_stage_we  = 1'b0;
        w_load      = 1'b0;
        w_valid_nxt = 1'b0;
        w_ovr_nxt   = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_fire) begin
                    w_stage_we = 1'b1;
                    w_mask_nxt = r_mask | w_en;
                    if (&(r_mask | w_en)) begin
                        w_load      = 1'b1;
                        w_mask_nxt  = '0;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                w_valid_nxt = 1'b1;
                w_ovr_nxt   = w_fire;
                if (ready_i) begin
                    w_valid_nxt = 1'b0;
                    w_mask_nxt  = '0;
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= COLLECT;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask      <= '0;
            r_stage_val <= '0;
            r_stage_err <= '0;
            value_o     <= '0;
            err_o       <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            r_mask    <= w_mask_nxt;
            valid_o   <= w_valid_nxt;
            overrun_o <= w_ovr_nxt;
            if (w_stage_we) begin
                r_stage_val <= w_stage_val_nxt;
                r_stage_err <= w_stage_err_nxt;
            end
            if (w_load) begin
                value_o <= w_stage_val_nxt;
                err_o   <= w_stage_err_nxt;
            end
        end
    end

endmodule
